// File: rtl/init_load_seq_pkg.sv
// rtl/init_load_seq_pkg.sv - shared state and failure-code encodings for the power-up load sequencer
package init_load_seq_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE  = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    localparam logic [1:0] FAIL_NONE = 2'd0;
    localparam logic [1:0] FAIL_ERR  = 2'd1;
    localparam logic [1:0] FAIL_TMO  = 2'd2;

    function automatic logic is_busy(state_t s);
        return (s == ST_SETTLE) || (s == ST_START) || (s == ST_WAIT) || (s == ST_BACKOFF);
    endfunction

endpackage

// File: rtl/init_load_seq_rise_det.sv
// rtl/init_load_seq_rise_det.sv - registers one input and flags its rising edge
module rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    assign rise = d & ~q;

endmodule

// File: rtl/init_load_seq.sv
// rtl/init_load_seq.sv - settle, start, wait with timeout and bounded retry for the RAM loaders
import init_load_seq_pkg::*;

module init_load_seq #(
    parameter int SETTLE_CYC  = 1000,
    parameter int TIMEOUT_CYC = 10_000_000,
    parameter int GAP_CYC     = 256,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 32
) (
    input  logic       sys_clk,
    input  logic       glbl_rst_n,
    input  logic       load_ram_done,
    input  logic       load_ram_error,
    input  logic       reload_req,
    output logic       load_start,
    output logic       busy,
    output logic       init_done,
    output logic       init_fail,
    output logic [1:0] fail_code,
    output logic [3:0] retry_cnt
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
    localparam logic [3:0]       MAX_R       = 4'(MAX_RETRY);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       fc_n, fail_kind;
    logic [3:0]       rc_n;
    logic             rise_done, rise_err, fail_hit;

    rise_det u_done_det (
        .clk   (sys_clk),
        .rst_n (glbl_rst_n),
        .d     (load_ram_done),
        .rise  (rise_done)
    );

    rise_det u_err_det (
        .clk   (sys_clk),
        .rst_n (glbl_rst_n),
        .d     (load_ram_error),
        .rise  (rise_err)
    );

    always_comb begin
        state_n   = state;
        fc_n      = fail_code;
        rc_n      = retry_cnt;
        fail_hit  = 1'b0;
        fail_kind = FAIL_ERR;
        cnt_n     = cnt;
        case (state)
            ST_SETTLE:  if (cnt == SETTLE_LAST) state_n = ST_START;
            ST_START:   state_n = ST_WAIT;
            ST_WAIT: begin
                // error outranks a coincident done
                if (rise_err) begin
                    fail_hit = 1'b1;
                end else if (rise_done) begin
                    state_n = ST_DONE;
                    fc_n    = FAIL_NONE;
                end else if (cnt == TMO_LAST) begin
                    fail_hit  = 1'b1;
                    fail_kind = FAIL_TMO;
                end
                if (fail_hit) begin
                    fc_n = fail_kind;
                    if (retry_cnt == MAX_R) begin
                        state_n = ST_FAIL;
                    end else begin
                        rc_n    = retry_cnt + 4'd1;
                        state_n = ST_BACKOFF;
                    end
                end
            end
            ST_BACKOFF: if (cnt == GAP_LAST) state_n = ST_START;
            ST_DONE, ST_FAIL: begin
                if (reload_req) begin
                    state_n = ST_START;
                    rc_n    = 4'd0;
                    fc_n    = FAIL_NONE;
                end
            end
            default:    state_n = ST_SETTLE;
        endcase
        if (state_n != state) begin
            cnt_n = '0;
        end else if (state == ST_SETTLE || state == ST_WAIT || state == ST_BACKOFF) begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state so they line up with the transition edge.
    always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
        if (!glbl_rst_n) begin
            state      <= ST_SETTLE;
            cnt        <= '0;
            fail_code  <= FAIL_NONE;
            retry_cnt  <= 4'd0;
            load_start <= 1'b0;
            busy       <= 1'b1;
            init_done  <= 1'b0;
            init_fail  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            fail_code  <= fc_n;
            retry_cnt  <= rc_n;
            load_start <= (state_n == ST_START);
            busy       <= is_busy(state_n);
            init_done  <= (state_n == ST_DONE);
            init_fail  <= (state_n == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_init_load_seq.sv
// tb/tb_init_load_seq.sv - scoreboard bench for init_load_seq with directed scenarios
module tb_init_load_seq;

    localparam int SETTLE = 10;
    localparam int TMO    = 50;
    localparam int GAP    = 8;

    localparam int K_START = 0;
    localparam int K_DONE  = 1;
    localparam int K_FAIL  = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [1:0] fc;
        logic [3:0] rc;
    } ev_t;

    logic       sys_clk = 1'b0;
    logic       glbl_rst_n = 1'b0;
    logic       load_ram_done = 1'b0;
    logic       load_ram_error = 1'b0;
    logic       reload_req = 1'b0;
    logic       load_start, busy, init_done, init_fail;
    logic [1:0] fail_code;
    logic [3:0] retry_cnt;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_fail = 0;
    ev_t exp_q[$];
    logic prev_done = 1'b0;
    logic prev_fail = 1'b0;

    init_load_seq #(
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TMO),
        .GAP_CYC     (GAP),
        .MAX_RETRY   (3),
        .CNT_W       (32)
    ) dut (
        .sys_clk        (sys_clk),
        .glbl_rst_n     (glbl_rst_n),
        .load_ram_done  (load_ram_done),
        .load_ram_error (load_ram_error),
        .reload_req     (reload_req),
        .load_start     (load_start),
        .busy           (busy),
        .init_done      (init_done),
        .init_fail      (init_fail),
        .fail_code      (fail_code),
        .retry_cnt      (retry_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= glbl_rst_n ? cyc + 1 : 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int c, input logic [1:0] fc, input logic [3:0] rc);
        ev_t e;
        e.kind = kind; e.cyc = c; e.fc = fc; e.rc = rc;
        exp_q.push_back(e);
    endtask

    task automatic take_ev(input int kind);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cyc %0d, expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.fc != fail_code || e.rc != retry_cnt) begin
                n_fail++;
                $display("FAIL event: got kind %0d cyc %0d fc %0d rc %0d, expected kind %0d cyc %0d fc %0d rc %0d",
                         kind, cyc, fail_code, retry_cnt, e.kind, e.cyc, e.fc, e.rc);
            end
        end
    endtask

    always @(negedge sys_clk) begin
        if (glbl_rst_n) begin
            if (load_start) take_ev(K_START);
            if (init_done && !prev_done) take_ev(K_DONE);
            if (init_fail && !prev_fail) take_ev(K_FAIL);
        end
        prev_done <= init_done;
        prev_fail <= init_fail;
    end

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge sys_clk);
    endtask

    task automatic do_reload(input int n);
        at_cyc(n); reload_req = 1'b1;
        at_cyc(n + 1); reload_req = 1'b0;
    endtask

    task automatic pulse_done(input int n);
        at_cyc(n); load_ram_done = 1'b1;
        at_cyc(n + 2); load_ram_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        @(negedge sys_clk);
        chk("rst_busy", int'(busy), 1);
        chk("rst_load_start", int'(load_start), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_init_fail", int'(init_fail), 0);
        chk("rst_fail_code", int'(fail_code), 0);
        chk("rst_retry_cnt", int'(retry_cnt), 0);

        // first start after settle, then done five cycles into WAIT
        expect_ev(K_START, 10, 2'd0, 4'd0);
        expect_ev(K_DONE, 16, 2'd0, 4'd0);
        @(negedge sys_clk); glbl_rst_n = 1'b1;
        pulse_done(15);
        at_cyc(17);
        chk("s1_busy", int'(busy), 0);
        chk("s1_init_done", int'(init_done), 1);

        // four errors exhaust three retries
        expect_ev(K_START, 21, 2'd0, 4'd0);
        expect_ev(K_START, 33, 2'd1, 4'd1);
        expect_ev(K_START, 45, 2'd1, 4'd2);
        expect_ev(K_START, 57, 2'd1, 4'd3);
        expect_ev(K_FAIL, 61, 2'd1, 4'd3);
        do_reload(20);
        for (int a = 0; a < 4; a++) begin
            at_cyc(21 + 12 * a + 3); load_ram_error = 1'b1;
            at_cyc(21 + 12 * a + 4); load_ram_error = 1'b0;
        end
        at_cyc(99);
        chk("s2_init_fail", int'(init_fail), 1);
        chk("s2_busy", int'(busy), 0);

        // timeout after exactly TMO cycles of WAIT, then done on retry
        expect_ev(K_START, 101, 2'd0, 4'd0);
        expect_ev(K_START, 160, 2'd2, 4'd1);
        expect_ev(K_DONE, 164, 2'd0, 4'd1);
        do_reload(100);
        at_cyc(151);
        chk("s3_pre_tmo_fc", int'(fail_code), 0);
        at_cyc(152);
        chk("s3_tmo_fc", int'(fail_code), 2);
        chk("s3_tmo_rc", int'(retry_cnt), 1);
        pulse_done(163);

        // coincident done and error counts as an error
        expect_ev(K_START, 171, 2'd0, 4'd0);
        expect_ev(K_START, 183, 2'd1, 4'd1);
        expect_ev(K_DONE, 187, 2'd0, 4'd1);
        do_reload(170);
        at_cyc(174); load_ram_done = 1'b1; load_ram_error = 1'b1;
        at_cyc(175); load_ram_error = 1'b0;
        chk("s4_init_done", int'(init_done), 0);
        chk("s4_busy", int'(busy), 1);
        chk("s4_rc", int'(retry_cnt), 1);
        at_cyc(176); load_ram_done = 1'b0;
        pulse_done(186);

        // held error level: later attempts time out, then reload from FAIL
        expect_ev(K_START, 191, 2'd0, 4'd0);
        expect_ev(K_START, 203, 2'd1, 4'd1);
        expect_ev(K_START, 262, 2'd2, 4'd2);
        expect_ev(K_START, 321, 2'd2, 4'd3);
        expect_ev(K_FAIL, 372, 2'd2, 4'd3);
        expect_ev(K_START, 391, 2'd0, 4'd0);
        do_reload(190);
        at_cyc(194); load_ram_error = 1'b1;
        at_cyc(253);
        chk("s5_still_err_code", int'(fail_code), 1);
        at_cyc(254);
        chk("s5_tmo_fc", int'(fail_code), 2);
        chk("s5_tmo_rc", int'(retry_cnt), 2);
        at_cyc(380); load_ram_error = 1'b0;
        do_reload(390);
        chk("s5_reload_rc", int'(retry_cnt), 0);

        // asynchronous reset in WAIT with retry_cnt nonzero, then full settle again
        expect_ev(K_START, 403, 2'd1, 4'd1);
        at_cyc(394); load_ram_error = 1'b1;
        at_cyc(395); load_ram_error = 1'b0;
        at_cyc(410);
        chk("s6_pre_rc", int'(retry_cnt), 1);
        #2 glbl_rst_n = 1'b0;
        #1;
        chk("s6_async_rc", int'(retry_cnt), 0);
        chk("s6_async_fc", int'(fail_code), 0);
        chk("s6_async_busy", int'(busy), 1);
        chk("s6_async_load_start", int'(load_start), 0);
        repeat (2) @(negedge sys_clk);
        expect_ev(K_START, 10, 2'd0, 4'd0);
        glbl_rst_n = 1'b1;
        at_cyc(9);
        chk("s6_settle_load_start", int'(load_start), 0);
        at_cyc(25);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
